// File: rtl/pipe_ctrl.sv
// Pipeline hold/bubble/flush controller with deferred PC redirect,
// output backpressure release timer, watchdog and performance counters.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   stall_req[NSTAGE]    stage i holds register i and all lower registers
//   io_full              output buffer full, holds the last register
//   flush_req, flush_idx redirect: clear registers 0..flush_idx
//   hold, bubble, flush  per-register keep / load-NOP / clear controls
//   redirect_ok          PC register takes the redirect target (= flush[0])
//   flush_pending        a redirect is waiting for IF to go idle
//   deadlock             sticky watchdog flag
//   stall_cnt, flush_cnt saturating performance counters
module pipe_ctrl #(
    parameter int NSTAGE   = 5,
    parameter int REL_CYC  = 2,
    parameter int WD_LIMIT = 1024,
    parameter int CNT_W    = 32,
    parameter int FW       = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              io_full,
    input  logic              flush_req,
    input  logic [FW-1:0]     flush_idx,
    output logic [NSTAGE-1:0] hold,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_ok,
    output logic              flush_pending,
    output logic              deadlock,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int RW = $clog2(REL_CYC + 1);
    localparam int WW = $clog2(WD_LIMIT + 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              ext_hold;
    logic [RW-1:0]     rel_cnt;
    logic [WW-1:0]     wd_cnt;
    logic [NSTAGE-1:0] raw;
    logic [NSTAGE-1:0] fl;
    logic [NSTAGE-1:0] bub;
    logic              f0;

    // Backpressure is released only after REL_CYC quiet cycles so a
    // briefly draining buffer does not chatter the whole pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_hold <= 1'b0;
            rel_cnt  <= '0;
        end else if (io_full) begin
            ext_hold <= 1'b1;
            rel_cnt  <= '0;
        end else if (ext_hold) begin
            if (rel_cnt == RW'(REL_CYC - 1)) begin
                ext_hold <= 1'b0;
                rel_cnt  <= '0;
            end else begin
                rel_cnt <= rel_cnt + 1'b1;
            end
        end
    end

    // A hold at stage i also freezes every upstream register.
    always_comb begin
        logic acc;
        acc = ext_hold;
        raw = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc    = acc | stall_req[i];
            raw[i] = acc;
        end
    end

    // The PC register may only take a redirect once IF is not stalled;
    // until then the redirect is parked in PENDING. Later requests while
    // parked flush downstream registers but add no second PC pulse.
    always_comb begin
        state_d = state_q;
        f0      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    if (!stall_req[0]) f0 = 1'b1;
                    else state_d = PENDING;
                end
            end
            PENDING: begin
                if (!stall_req[0]) begin
                    f0      = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fl    = '0;
        fl[0] = f0;
        for (int i = 1; i < NSTAGE; i++) begin
            fl[i] = flush_req && (FW'(i) <= flush_idx);
        end
    end

    // A moving register below a held one must take a NOP, otherwise the
    // held instruction would be duplicated downstream.
    always_comb begin
        bub = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            bub[i] = raw[i-1] & ~raw[i] & ~fl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= '0;
            deadlock <= 1'b0;
        end else if (!raw[0]) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt != WW'(WD_LIMIT)) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WW'(WD_LIMIT - 1)) deadlock <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (raw[0] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_req && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hold          = rst ? '0 : (raw & ~fl);
    assign bubble        = rst ? '0 : bub;
    assign flush         = rst ? '0 : fl;
    assign redirect_ok   = rst ? 1'b0 : f0;
    assign flush_pending = rst ? 1'b0 : (state_q == PENDING);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl
// (NSTAGE=5, REL_CYC=2, WD_LIMIT=8).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  stall_req;
    logic        io_full;
    logic        flush_req;
    logic [2:0]  flush_idx;
    logic [4:0]  hold;
    logic [4:0]  bubble;
    logic [4:0]  flush;
    logic        redirect_ok;
    logic        flush_pending;
    logic        deadlock;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_cmp;
    int n_err;

    pipe_ctrl #(
        .NSTAGE  (5),
        .REL_CYC (2),
        .WD_LIMIT(8),
        .CNT_W   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .io_full      (io_full),
        .flush_req    (flush_req),
        .flush_idx    (flush_idx),
        .hold         (hold),
        .bubble       (bubble),
        .flush        (flush),
        .redirect_ok  (redirect_ok),
        .flush_pending(flush_pending),
        .deadlock     (deadlock),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall_req = '0;
        io_full   = 1'b0;
        flush_req = 1'b0;
        flush_idx = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".hold"}, 32'(hold), 0);
        chk({tag, ".bubble"}, 32'(bubble), 0);
        chk({tag, ".flush"}, 32'(flush), 0);
        chk({tag, ".redir"}, 32'(redirect_ok), 0);
        chk({tag, ".pend"}, 32'(flush_pending), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset with busy inputs: every control output must stay low
        rst       = 1'b1;
        stall_req = 5'b11111;
        io_full   = 1'b0;
        flush_req = 1'b1;
        flush_idx = 3'd4;
        #1;
        chk_all_zero("rst_busy");
        cyc();
        cyc();
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_deadlock", 32'(deadlock), 0);
        cyc();
        rst = 1'b0;
        idle_in();
        #1;
        chk_all_zero("post_rst");

        // Mid-pipe stall: upstream held, bubble behind it
        cyc();
        stall_req = 5'b00100;
        #1;
        chk("s2_hold", 32'(hold), 32'b00111);
        chk("s2_bubble", 32'(bubble), 32'b01000);
        chk("s2_flush", 32'(flush), 0);
        cyc();
        stall_req = '0;
        #1;
        chk("s2_hold_off", 32'(hold), 0);
        chk("s2_stall_cnt", stall_cnt, 1);

        // io_full pulse: two cycles of full hold, then release
        cyc();
        io_full = 1'b1;
        #1;
        chk("io_c3_hold", 32'(hold), 0);
        cyc();
        io_full = 1'b0;
        #1;
        chk("io_c4_hold", 32'(hold), 32'b11111);
        chk("io_c4_bubble", 32'(bubble), 0);
        cyc();
        #1;
        chk("io_c5_hold", 32'(hold), 32'b11111);
        cyc();
        #1;
        chk("io_c6_hold", 32'(hold), 0);
        chk("io_stall_cnt", stall_cnt, 3);
        chk("io_deadlock", 32'(deadlock), 0);

        // Immediate redirect in IDLE
        cyc();
        flush_req = 1'b1;
        flush_idx = 3'd2;
        #1;
        chk("fl_idle_flush", 32'(flush), 32'b00111);
        chk("fl_idle_redir", 32'(redirect_ok), 1);
        chk("fl_idle_pend", 32'(flush_pending), 0);
        chk("fl_idle_cnt0", flush_cnt, 0);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("fl_idle_cnt1", flush_cnt, 1);
        chk("fl_idle_off", 32'(flush), 0);

        // Flush overrides hold on every flushed register
        cyc();
        flush_req = 1'b1;
        flush_idx = 3'd4;
        stall_req = 5'b10000;
        #1;
        chk("fl_all_flush", 32'(flush), 32'b11111);
        chk("fl_all_hold", 32'(hold), 0);
        chk("fl_all_bubble", 32'(bubble), 0);
        chk("fl_all_redir", 32'(redirect_ok), 1);

        // Partial flush under a stall at stage 3
        cyc();
        flush_idx = 3'd1;
        stall_req = 5'b01000;
        #1;
        chk("fl_part_flush", 32'(flush), 32'b00011);
        chk("fl_part_hold", 32'(hold), 32'b01100);
        chk("fl_part_bubble", 32'(bubble), 32'b10000);
        cyc();
        idle_in();
        #1;
        chk("fl_part_fcnt", flush_cnt, 3);
        chk("fl_part_scnt", stall_cnt, 5);

        // Deferred redirect while IF is stalled, second request ignored
        cyc();
        flush_req = 1'b1;
        flush_idx = 3'd3;
        stall_req = 5'b00001;
        #1;
        chk("pd_c0_flush", 32'(flush), 32'b01110);
        chk("pd_c0_hold", 32'(hold), 32'b00001);
        chk("pd_c0_bubble", 32'(bubble), 0);
        chk("pd_c0_redir", 32'(redirect_ok), 0);
        chk("pd_c0_pend", 32'(flush_pending), 0);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("pd_c1_pend", 32'(flush_pending), 1);
        chk("pd_c1_flush", 32'(flush), 0);
        chk("pd_c1_hold", 32'(hold), 32'b00001);
        chk("pd_c1_bubble", 32'(bubble), 32'b00010);
        cyc();
        flush_req = 1'b1;
        flush_idx = 3'd2;
        #1;
        chk("pd_c2_flush", 32'(flush), 32'b00110);
        chk("pd_c2_pend", 32'(flush_pending), 1);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("pd_c3_flush", 32'(flush), 0);
        chk("pd_c3_pend", 32'(flush_pending), 1);
        cyc();
        stall_req = '0;
        #1;
        chk("pd_c4_flush", 32'(flush), 32'b00001);
        chk("pd_c4_redir", 32'(redirect_ok), 1);
        chk("pd_c4_pend", 32'(flush_pending), 1);
        chk("pd_c4_hold", 32'(hold), 0);
        cyc();
        #1;
        chk("pd_c5_flush", 32'(flush), 0);
        chk("pd_c5_redir", 32'(redirect_ok), 0);
        chk("pd_c5_pend", 32'(flush_pending), 0);
        chk("pd_fcnt", flush_cnt, 5);
        chk("pd_scnt", stall_cnt, 9);

        // Reset while PENDING drops the parked redirect
        cyc();
        flush_req = 1'b1;
        flush_idx = 3'd0;
        stall_req = 5'b00001;
        #1;
        chk("rp_c0_flush", 32'(flush), 0);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("rp_c1_pend", 32'(flush_pending), 1);
        cyc();
        rst       = 1'b1;
        stall_req = '0;
        #1;
        chk_all_zero("rp_c2");
        cyc();
        rst = 1'b0;
        #1;
        chk_all_zero("rp_c3");
        chk("rp_c3_scnt", stall_cnt, 0);
        chk("rp_c3_fcnt", flush_cnt, 0);
        cyc();
        #1;
        chk("rp_c4_flush", 32'(flush), 0);
        chk("rp_c4_pend", 32'(flush_pending), 0);

        // Watchdog: 10-cycle stall at stage 1, deadlock from cycle 8
        for (int k = 0; k < 10; k++) begin
            cyc();
            stall_req = 5'b00010;
            #1;
            chk($sformatf("wd_c%0d_dl", k), 32'(deadlock),
                (k >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("wd_c%0d_hold", k), 32'(hold), 32'b00011);
            chk($sformatf("wd_c%0d_bub", k), 32'(bubble), 32'b00100);
        end
        cyc();
        stall_req = '0;
        #1;
        chk("wd_drop_dl", 32'(deadlock), 1);
        chk("wd_scnt", stall_cnt, 10);
        cyc();
        cyc();
        cyc();
        #1;
        chk("wd_sticky", 32'(deadlock), 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("wd_rst_dl", 32'(deadlock), 0);

        // A flush does not cancel the backpressure hold timer
        cyc();
        io_full = 1'b1;
        cyc();
        io_full   = 1'b0;
        flush_req = 1'b1;
        flush_idx = 3'd4;
        #1;
        chk("xf_c1_flush", 32'(flush), 32'b11111);
        chk("xf_c1_hold", 32'(hold), 0);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("xf_c2_hold", 32'(hold), 32'b11111);
        cyc();
        #1;
        chk("xf_c3_hold", 32'(hold), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 NSTAGE, 5, number of pipeline registers; index 0 = PC register, NSTAGE-1 = last (writeback) register.
REQ-002 REL_CYC, 2, consecutive io_full-low cycles needed before the external hold releases; minimum 1.
REQ-003 WD_LIMIT, 1024, consecutive cycles of hold on register 0 that raise deadlock.
REQ-004 CNT_W, 32, width of the performance counters; FW = clog2(NSTAGE).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 stall_req  input  NSTAGE  bit i: stage request that holds register i and every lower-index register.
REQ-008 io_full  input  1  output buffer full; backpressure on register NSTAGE-1.
REQ-009 flush_req  input  1  control-flow redirect resolved this cycle.
REQ-010 flush_idx  input  FW  highest register index to clear; registers 0..flush_idx are flushed.
REQ-011 hold  output  NSTAGE  register i keeps its contents this cycle.
REQ-012 bubble  output  NSTAGE  register i loads a NOP this cycle.
REQ-013 flush  output  NSTAGE  register i is cleared to NOP this cycle.
REQ-014 redirect_ok  output  1  PC register loads the redirect target this cycle; always equals flush[0].
REQ-015 flush_pending  output  1  a redirect is waiting for IF to go idle.
REQ-016 deadlock  output  1  sticky watchdog flag.
REQ-017 stall_cnt  output  CNT_W  cycles in which register 0 was held.
REQ-018 flush_cnt  output  CNT_W  accepted flush requests.

Function
REQ-019 ext_hold SHALL be a registered flag with the following behaviour:
- io_full=1 at an edge: ext_hold<=1 and rel_cnt<=0.
- io_full=0 while ext_hold=1: rel_cnt increments; at the edge where rel_cnt+1==REL_CYC, ext_hold<=0 and rel_cnt<=0.
REQ-020 Raw hold SHALL be a same-cycle combinational cascade:
- raw[NSTAGE-1] = stall_req[NSTAGE-1] | ext_hold.
- raw[i] = stall_req[i] | raw[i+1] for i < NSTAGE-1.
REQ-021 Outputs hold[i] = raw[i] & ~flush[i], and bubble[0] = 0.
REQ-022 For i>=1, bubble[i] = raw[i-1] & ~raw[i] & ~flush[i], so a held upstream register never duplicates into a moving downstream register.
REQ-023 Flush FSM states SHALL be IDLE and PENDING.
REQ-024 Any cycle with flush_req=1 SHALL assert flush[i] for 1<=i<=flush_idx in that same cycle, regardless of FSM state or raw hold.
REQ-025 In IDLE with flush_req=1 and stall_req[0]=0: flush[0]=1 in the same cycle; the FSM stays in IDLE.
REQ-026 In IDLE with flush_req=1 and stall_req[0]=1: flush[0]=0; next state is PENDING.
REQ-027 In PENDING: flush_pending=1.
- While stall_req[0]=1, flush[0]=0 and hold[0]=raw[0].
- In the first cycle with stall_req[0]=0, flush[0]=1 and next state is IDLE.
REQ-028 A flush_req arriving in PENDING SHALL apply REQ-024 and SHALL NOT create a second pending entry; exactly one deferred flush[0] pulse occurs.
REQ-029 stall_cnt SHALL increment on each cycle with raw[0]=1, saturating at all-ones.
REQ-030 flush_cnt SHALL increment on each cycle with flush_req=1, saturating at all-ones.
REQ-031 wd_cnt SHALL count consecutive raw[0]=1 cycles and clear on raw[0]=0; on reaching WD_LIMIT, deadlock<=1 and remains 1 until rst.
REQ-032 A flush SHALL NOT clear ext_hold, rel_cnt or wd_cnt.

Reset
REQ-033 An edge with rst=1 SHALL set:
- ext_hold=0, rel_cnt=0;
- state IDLE;
- wd_cnt=0, deadlock=0;
- stall_cnt=0, flush_cnt=0.
REQ-034 While rst=1, every output bit SHALL be driven 0: hold, bubble, flush, redirect_ok, flush_pending.
REQ-035 rst asserted in PENDING SHALL discard the pending flush with no flush[0] pulse.

Verification (NSTAGE=5, REL_CYC=2, WD_LIMIT=8)
REQ-036 stall_req=5'b00100 in one cycle, no other activity -> same cycle hold=5'b00111, bubble=5'b01000.
REQ-037 io_full=1 in cycle 3 only -> ext_hold=1 during cycles 4-5 and 0 from cycle 6; hold=5'b11111 in cycles 4-5.
REQ-038 IDLE, flush_req=1, flush_idx=2, stall_req=0 -> same cycle flush=5'b00111, redirect_ok=1, flush_cnt 0->1.
REQ-039 flush_req=1, flush_idx=3, stall_req[0]=1 for cycles 0-3 -> cycle 0 flush=5'b01110, flush_pending=1 in cycles 1-4, single flush[0] pulse in cycle 4.
REQ-040 stall_req[1]=1 held for 10 cycles -> deadlock=1 from cycle 8, still 1 after stall_req drops, cleared only by rst; stall_cnt=10.
REQ-041 rst=1 in cycle 2 while PENDING -> all outputs 0 in cycle 2, IDLE afterwards, no flush[0] pulse.
